// File: rtl/long_to_double.sv
// long_to_double: signed 64-bit integer to IEEE-754 binary64 converter.
// Handshaked input (input_a/_stb/_ack) and output (output_z/_stb/_ack).
//
// Ports:
//   clk, rst                   - clock, async active-high reset
//   input_a[63:0]              - two's-complement operand
//   input_a_stb / input_a_ack  - operand valid / block ready
//   output_z[63:0]             - binary64 result
//   output_z_stb / output_z_ack- result valid / consumer accepts
//
// Build option: define LONG_TO_DOUBLE_ROUND_NEAREST_EN for
// round-to-nearest-even; otherwise the mantissa is truncated.
module long_to_double (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

`ifdef LONG_TO_DOUBLE_ROUND_NEAREST_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] value_q, value_d;
  logic [6:0]  exp_q, exp_d;
  logic [51:0] mant_q, mant_d;
  logic        sign_q, sign_d;
  logic        ack_q, ack_d;
  logic [63:0] z_q, z_d;
  logic        zstb_q, zstb_d;

  logic        guard;
  logic        round_bit;
  logic        sticky;
  logic        round_up;
  logic        carry;

  // value_q[63] is the hidden bit once normalised.
  assign guard     = value_q[10];
  assign round_bit = value_q[9];
  assign sticky    = |value_q[8:0];
  assign round_up  = ROUND_EN & guard
                   & (round_bit | sticky | value_q[11]);
  // Hidden bit is always 1, so all-ones fraction means carry-out.
  assign carry     = round_up & (&value_q[62:11]);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GET_A:
        if (ack_q && input_a_stb) state_d = CONVERT_0;
      CONVERT_0:
        state_d = (a_q == 64'd0) ? PUT_Z : NORMALISE;
      NORMALISE:
        if (value_q[63]) state_d = ROUND;
      ROUND:
        state_d = PACK;
      PACK:
        state_d = PUT_Z;
      PUT_Z:
        if (output_z_ack) state_d = GET_A;
      default:
        state_d = GET_A;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    a_d     = a_q;
    value_d = value_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    sign_d  = sign_q;
    ack_d   = 1'b0;
    z_d     = z_q;
    zstb_d  = zstb_q;
    unique case (state_q)
      GET_A: begin
        if (ack_q && input_a_stb) begin
          a_d   = input_a;
          ack_d = 1'b0;
        end else begin
          ack_d = 1'b1;
        end
      end
      CONVERT_0: begin
        if (a_q == 64'd0) begin
          z_d    = 64'd0;
          zstb_d = 1'b1;
        end else begin
          sign_d  = a_q[63];
          // -(2^63) wraps to itself, which is the right magnitude.
          value_d = a_q[63] ? (~a_q + 64'd1) : a_q;
          exp_d   = 7'd63;
        end
      end
      NORMALISE: begin
        if (!value_q[63]) begin
          value_d = {value_q[62:0], 1'b0};
          exp_d   = exp_q - 7'd1;
        end
      end
      ROUND: begin
        // On carry the fraction wraps to zero and the exponent bumps.
        mant_d = value_q[62:11] + {51'd0, round_up};
        exp_d  = exp_q + {6'd0, carry};
      end
      PACK: begin
        z_d    = {sign_q, 11'd1023 + {4'd0, exp_q}, mant_q};
        zstb_d = 1'b1;
      end
      PUT_Z: begin
        if (output_z_ack) zstb_d = 1'b0;
      end
      default: begin
        ack_d  = 1'b0;
        zstb_d = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      value_q <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      sign_q  <= 1'b0;
      ack_q   <= 1'b0;
      z_q     <= '0;
      zstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      value_q <= value_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      sign_q  <= sign_d;
      ack_q   <= ack_d;
      z_q     <= z_d;
      zstb_q  <= zstb_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = z_q;
  assign output_z_stb = zstb_q;

endmodule
